fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter PC_INIT, default 32'h00000000, meaning the PC value loaded on reset.
REQ-002 SHALL have port CLK  in  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port RST  in  1  reset; one clock, reset synchronous and active-high.
REQ-004 SHALL have port ihit  in  1  instruction memory returns valid imemload this cycle.
REQ-005 SHALL have port imemload  in  32  instruction word from instruction memory.
REQ-006 SHALL have port stall  in  1  hazard unit holds the IF/ID latch.
REQ-007 SHALL have port redirect  in  1  taken branch/jump resolved downstream.
REQ-008 SHALL have port redirect_addr  in  32  redirect target.
REQ-009 SHALL have port halt  in  1  halt instruction detected downstream.
REQ-010 SHALL have port imemREN  out  1  instruction read request.
REQ-011 SHALL have port imemaddr  out  32  fetch address; always equals PC.
REQ-012 SHALL have port instr_out  out  32  instruction presented to the IF/ID latch.
REQ-013 SHALL have port next_addr  out  32  PC+4 presented to the IF/ID latch.
REQ-014 SHALL have port fd_enable  out  1  IF/ID latch load strobe.
REQ-015 SHALL have port fd_flush  out  1  IF/ID latch clear strobe.
REQ-016 SHALL have port fetch_count  out  32  number of instructions delivered.

Function
REQ-017 SHALL implement states RUN, HOLD, HALTED; HOLD means one instruction is captured in the skid buffer.
REQ-018 SHALL set next_addr = PC + 4, modulo 2^32, with wrap from 32'hFFFFFFFC to 0.
REQ-019 SHALL drive imemREN = 1 in RUN only, and 0 in HOLD and HALTED.
REQ-020 SHALL drive instr_out = imemload in RUN and the buffered word in HOLD.
REQ-021 SHALL, in RUN with ihit=1, stall=0, redirect=0, halt=0: assert fd_enable the same cycle, set PC <= PC+4, increment fetch_count.
REQ-022 SHALL, in RUN with ihit=1, stall=1, redirect=0, halt=0: capture imemload into the buffer, hold PC, set state to HOLD, and keep fd_enable at 0.
REQ-023 SHALL, in RUN with ihit=0: keep PC unchanged and keep fd_enable at 0 (miss wait, unbounded).
REQ-024 SHALL, in HOLD with stall=0: assert fd_enable, set PC <= PC+4, increment fetch_count, and return to RUN without a new memory read for the held word.
REQ-025 SHALL, in HOLD with stall=1: hold PC, the buffer and the state.
REQ-026 SHALL, on redirect=1 and halt=0 in RUN or HOLD, regardless of ihit/stall:
  - set PC <= {redirect_addr[31:2], 2'b00};
  - assert fd_flush for that cycle, with fd_enable=0;
  - invalidate the buffer and go to RUN;
  - leave fetch_count unchanged.
REQ-027 SHALL, on halt=1 in any state, deassert fd_enable and go to HALTED, with halt taking priority over a simultaneous redirect and ihit.
REQ-028 SHALL, in HALTED: hold PC, drive imemREN=0, fd_enable=0, fd_flush=0, and ignore all inputs except RST.
REQ-029 SHALL never assert fd_enable and fd_flush in the same cycle.
REQ-030 SHALL wrap fetch_count from 32'hFFFFFFFF to 0.

Reset
REQ-031 SHALL, while RST=1 at a rising edge, load PC=PC_INIT, state=RUN, buffer=0 (invalid), fetch_count=0.
REQ-032 SHALL force imemREN=0, fd_enable=0, fd_flush=0 combinationally while RST=1.
REQ-033 SHALL give reset priority over redirect, halt, stall and ihit, including when reset is asserted in HOLD or HALTED.
REQ-034 SHALL assert imemREN=1 with imemaddr=PC_INIT in the first cycle after RST deasserts.

Verification
REQ-035 SHALL cover: reset, then ihit=1 for 3 cycles, stall=0 -> fd_enable=1 each cycle, imemaddr 0,4,8, then 12, fetch_count=3.
REQ-036 SHALL cover: ihit=1 with stall=1 at PC=0x10, imemload=0xAABBCCDD, stall held 2 more cycles -> imemREN=0, instr_out=0xAABBCCDD; on stall=0 -> fd_enable=1, next PC=0x14.
REQ-037 SHALL cover: redirect=1, redirect_addr=0x00000103, in HOLD -> fd_flush=1, fd_enable=0, next PC=0x100, state RUN, fetch_count unchanged.
REQ-038 SHALL cover: halt=1 with redirect=1 and ihit=1 at PC=0x20 -> HALTED, PC stays 0x20, imemREN=0 for 5 following cycles despite ihit=1.
REQ-039 SHALL cover: PC=0xFFFFFFFC, ihit=1, stall=0 -> next_addr=0, PC wraps to 0.
REQ-040 SHALL cover: RST=1 asserted mid-HOLD -> next cycle PC=PC_INIT, fetch_count=0, and imemREN=0 during reset.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, one-entry skid buffer for stalled hits,
// redirect/halt handling, and a delivered-instruction counter.
module fetch_unit #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_addr,
    input  logic        halt,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    output logic [31:0] instr_out,
    output logic [31:0] next_addr,
    output logic        fd_enable,
    output logic        fd_flush,
    output logic [31:0] fetch_count
);

    localparam int unsigned WORD_W = 32;
    localparam logic [WORD_W-1:0] PC_STEP = WORD_W'(4);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HOLD   = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t            state, next_state;
    logic [WORD_W-1:0] pc, next_pc;
    logic [WORD_W-1:0] buf_word, next_buf;
    logic [WORD_W-1:0] fetch_cnt, next_cnt;
    logic [WORD_W-1:0] pc_plus4;
    logic [WORD_W-1:0] redirect_pc;
    logic              unused_raddr_lo;

    assign pc_plus4        = pc + PC_STEP;
    assign redirect_pc     = {redirect_addr[WORD_W-1:2], 2'b00};
    assign unused_raddr_lo = ^redirect_addr[1:0];

    assign imemaddr    = pc;
    assign next_addr   = pc_plus4;
    assign fetch_count = fetch_cnt;

    // State register; reset is synchronous and overrides everything.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= RUN;
            pc        <= PC_INIT;
            buf_word  <= '0;
            fetch_cnt <= '0;
        end else begin
            state     <= next_state;
            pc        <= next_pc;
            buf_word  <= next_buf;
            fetch_cnt <= next_cnt;
        end
    end

    // Next-state and strobe logic; halt outranks redirect, redirect outranks hit/stall.
    always_comb begin
        next_state = state;
        next_pc    = pc;
        next_buf   = buf_word;
        next_cnt   = fetch_cnt;
        imemREN    = 1'b0;
        fd_enable  = 1'b0;
        fd_flush   = 1'b0;
        instr_out  = (state == HOLD) ? buf_word : imemload;

        if (!RST) begin
            case (state)
                RUN: begin
                    imemREN = 1'b1;
                    if (halt) begin
                        next_state = HALTED;
                    end else if (redirect) begin
                        fd_flush = 1'b1;
                        next_pc  = redirect_pc;
                        next_buf = '0;
                    end else if (ihit && !stall) begin
                        fd_enable = 1'b1;
                        next_pc   = pc_plus4;
                        next_cnt  = fetch_cnt + WORD_W'(1);
                    end else if (ihit) begin
                        next_buf   = imemload;
                        next_state = HOLD;
                    end
                end
                HOLD: begin
                    if (halt) begin
                        next_state = HALTED;
                    end else if (redirect) begin
                        fd_flush   = 1'b1;
                        next_pc    = redirect_pc;
                        next_buf   = '0;
                        next_state = RUN;
                    end else if (!stall) begin
                        fd_enable  = 1'b1;
                        next_pc    = pc_plus4;
                        next_cnt   = fetch_cnt + WORD_W'(1);
                        next_buf   = '0;
                        next_state = RUN;
                    end
                end
                HALTED: begin
                    next_state = HALTED;
                end
                default: begin
                    next_state = RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized fetch-stage bench: directed scenarios with literal expectations,
// then random traffic checked every cycle against a behavioural model.
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ihit;
    logic [31:0] imemload;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic        halt;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic [31:0] instr_out;
    logic [31:0] next_addr;
    logic        fd_enable;
    logic        fd_flush;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;

    fetch_unit #(.PC_INIT(32'h0000_0000)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .imemload(imemload), .stall(stall),
        .redirect(redirect), .redirect_addr(redirect_addr), .halt(halt),
        .imemREN(imemREN), .imemaddr(imemaddr), .instr_out(instr_out),
        .next_addr(next_addr), .fd_enable(fd_enable), .fd_flush(fd_flush),
        .fetch_count(fetch_count)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle's inputs after the rising edge, then settle to mid-cycle.
    task automatic cyc(input logic r, input logic ih, input logic [31:0] im, input logic st,
                       input logic rd, input logic [31:0] ra, input logic hl);
        @(posedge CLK);
        #1;
        RST = r; ihit = ih; imemload = im; stall = st;
        redirect = rd; redirect_addr = ra; halt = hl;
        @(negedge CLK);
        #1;
    endtask

    // Behavioural model: PC, count, halted flag, and an optional held word.
    logic [31:0] m_pc, m_cnt, m_word;
    bit          m_halted, m_held, armed = 0;

    always @(negedge CLK) begin
        bit          e_ren, e_en, e_fl;
        e_ren = !RST && !m_halted && !m_held;
        e_en  = !RST && !m_halted && !halt && !redirect && (m_held ? !stall : (ihit && !stall));
        e_fl  = !RST && !m_halted && !halt && redirect;
        if (armed) begin
            chk("m_imemREN", 32'(imemREN), 32'(e_ren));
            chk("m_fd_enable", 32'(fd_enable), 32'(e_en));
            chk("m_fd_flush", 32'(fd_flush), 32'(e_fl));
            chk("m_imemaddr", imemaddr, m_pc);
            chk("m_next_addr", next_addr, m_pc + 32'd4);
            chk("m_fetch_count", fetch_count, m_cnt);
            if (m_held || (e_ren && ihit))
                chk("m_instr_out", instr_out, m_held ? m_word : imemload);
        end
        if (RST) begin
            m_pc = 32'h0; m_cnt = 0; m_halted = 0; m_held = 0; m_word = 0;
            armed = 1;
        end else if (m_halted) begin
            m_halted = 1;
        end else if (halt) begin
            m_halted = 1; m_held = 0;
        end else if (redirect) begin
            m_pc = redirect_addr & ~32'd3; m_held = 0;
        end else if (e_en) begin
            m_pc = m_pc + 32'd4; m_cnt = m_cnt + 1; m_held = 0;
        end else if (!m_held && ihit && stall) begin
            m_held = 1; m_word = imemload;
        end
    end

    initial begin
        RST = 1; ihit = 0; imemload = 0; stall = 0; redirect = 0; redirect_addr = 0; halt = 0;

        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("rst_ren", 32'(imemREN), 0);
        chk("rst_en", 32'(fd_enable), 0);
        cyc(1, 1, 32'h1, 0, 1, 32'h44, 1);
        chk("rst_prio_flush", 32'(fd_flush), 0);
        chk("rst_prio_ren", 32'(imemREN), 0);

        // Three consecutive hits
        for (int k = 0; k < 3; k++) begin
            cyc(0, 1, 32'h1000 + 32'(k), 0, 0, 0, 0);
            chk("seq_addr", imemaddr, 32'(4 * k));
            chk("seq_en", 32'(fd_enable), 1);
            chk("seq_instr", instr_out, 32'h1000 + 32'(k));
        end
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("seq_addr12", imemaddr, 32'hC);
        chk("seq_count3", fetch_count, 32'd3);
        cyc(0, 1, 32'h5, 0, 0, 0, 0);

        // Stalled hit at 0x10 goes to the skid buffer
        cyc(0, 1, 32'hAABBCCDD, 1, 0, 0, 0);
        chk("hold_entry_addr", imemaddr, 32'h10);
        chk("hold_entry_en", 32'(fd_enable), 0);
        for (int k = 0; k < 2; k++) begin
            cyc(0, 1, 32'h11111111, 1, 0, 0, 0);
            chk("hold_ren", 32'(imemREN), 0);
            chk("hold_instr", instr_out, 32'hAABBCCDD);
        end
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("hold_release_en", 32'(fd_enable), 1);
        chk("hold_release_instr", instr_out, 32'hAABBCCDD);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("hold_next_pc", imemaddr, 32'h14);
        chk("hold_count", fetch_count, 32'd5);

        // Redirect out of HOLD
        cyc(0, 1, 32'h22222222, 1, 0, 0, 0);
        cyc(0, 1, 32'h0, 1, 1, 32'h103, 0);
        chk("redir_flush", 32'(fd_flush), 1);
        chk("redir_en", 32'(fd_enable), 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("redir_pc", imemaddr, 32'h100);
        chk("redir_ren", 32'(imemREN), 1);
        chk("redir_count", fetch_count, 32'd5);

        // Halt beats redirect and hit at 0x20
        cyc(0, 0, 0, 0, 1, 32'h20, 0);
        cyc(0, 1, 32'h7, 0, 1, 32'h40, 1);
        chk("halt_addr", imemaddr, 32'h20);
        chk("halt_en", 32'(fd_enable), 0);
        chk("halt_flush", 32'(fd_flush), 0);
        for (int k = 0; k < 5; k++) begin
            cyc(0, 1, 32'h9, 0, 0, 0, 0);
            chk("halted_ren", 32'(imemREN), 0);
            chk("halted_pc", imemaddr, 32'h20);
        end
        cyc(1, 1, 0, 0, 0, 0, 0);
        chk("halted_rst_ren", 32'(imemREN), 0);

        // PC wrap
        cyc(0, 0, 0, 0, 1, 32'hFFFFFFFF, 0);
        chk("wrap_flush", 32'(fd_flush), 1);
        cyc(0, 1, 32'h3, 0, 0, 0, 0);
        chk("wrap_pc", imemaddr, 32'hFFFFFFFC);
        chk("wrap_next", next_addr, 32'h0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("wrap_pc0", imemaddr, 32'h0);
        chk("wrap_count", fetch_count, 32'd1);

        // Reset mid-HOLD
        cyc(0, 1, 32'h55, 1, 0, 0, 0);
        cyc(0, 1, 32'h66, 1, 0, 0, 0);
        chk("midhold_ren", 32'(imemREN), 0);
        cyc(1, 1, 32'h77, 1, 1, 32'h80, 1);
        chk("midhold_rst_ren", 32'(imemREN), 0);
        chk("midhold_rst_en", 32'(fd_enable), 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("midhold_pc", imemaddr, 32'h0);
        chk("midhold_count", fetch_count, 32'd0);
        chk("midhold_ren1", 32'(imemREN), 1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] ra;
            ra = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(0, 15))) : $urandom;
            cyc($urandom_range(0, 59) == 0, $urandom_range(0, 2) != 0, $urandom,
                $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0, ra,
                $urandom_range(0, 39) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
